// File: rtl/fb_pixel_writer_if.sv
// fb_pixel_writer_if: pixel-stream handshake, clear request and framebuffer write port.
// Latency: none, wires only.
// Backpressure: ready_out is driven by the writer and qualifies valid_in.
interface fb_pixel_writer_if #(
  parameter int COLOR_WIDTH = 8,
  parameter int ADDR_WIDTH  = 9
);
  logic                   valid_in;
  logic [19:0]            pixel_in;
  logic [COLOR_WIDTH-1:0] color_in;
  logic                   last_in;
  logic                   ready_out;
  logic                   clear_in;
  logic [COLOR_WIDTH-1:0] clear_color_in;
  logic                   busy_out;
  logic                   fb_we_out;
  logic [ADDR_WIDTH-1:0]  fb_addr_out;
  logic [COLOR_WIDTH-1:0] fb_data_out;
  logic                   tri_done_out;
  logic [15:0]            clipped_count_out;

  // Writer side.
  modport slave (
    input  valid_in, pixel_in, color_in, last_in, clear_in, clear_color_in,
    output ready_out, busy_out, fb_we_out, fb_addr_out, fb_data_out,
           tri_done_out, clipped_count_out
  );

  // Rasterizer / controller side.
  modport master (
    output valid_in, pixel_in, color_in, last_in, clear_in, clear_color_in,
    input  ready_out, busy_out, fb_we_out, fb_addr_out, fb_data_out,
           tri_done_out, clipped_count_out
  );
endinterface

// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer: writes rasterized pixels (clipped to the screen) into a framebuffer BRAM, plus a full-screen clear sweep.
// Latency: a beat accepted at edge N is on the BRAM write port in the cycle after edge N+1.
// Backpressure: ready_out drops while a clear is pending or running; beats stall until the sweep finishes.
module fb_pixel_writer #(
  parameter int WIDTH       = 40,
  parameter int HEIGHT      = 10,
  parameter int COLOR_WIDTH = 8,
  parameter int ADDR_WIDTH  = 9
) (
  input  logic             clk_in,
  input  logic             rst_in,
  fb_pixel_writer_if.slave bus
);
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } pixel_t;

  typedef enum logic {DRAW, CLEAR} state_t;

  // Counter runs one past the last address so the final write and the
  // return to DRAW land on separate edges; one spare bit avoids wrap.
  localparam int NPIX = WIDTH * HEIGHT;
  localparam logic [ADDR_WIDTH:0] CLEAR_END = (ADDR_WIDTH+1)'(NPIX);

  state_t                 state, state_d;
  logic                   clear_pending;
  logic [COLOR_WIDTH-1:0] clear_color;
  logic [ADDR_WIDTH:0]    clear_cnt;
  logic                   start_clear, clear_finish;

  pixel_t                 pix_in;
  logic                   ready, accept;

  logic                   s1_valid, s1_last, s1_inb;
  pixel_t                 s1_pix;
  logic [COLOR_WIDTH-1:0] s1_color;
  logic [ADDR_WIDTH-1:0]  lin_addr;

  logic                   s2_valid;
  logic                   fb_we, tri_done;
  logic [ADDR_WIDTH-1:0]  fb_addr;
  logic [COLOR_WIDTH-1:0] fb_data;
  logic [15:0]            clipped;

  assign pix_in   = bus.pixel_in;
  assign accept   = bus.valid_in && ready;
  assign lin_addr = ADDR_WIDTH'(32'(s1_pix.y) * 32'(WIDTH) + 32'(s1_pix.x));

  // Next-state and handshake decode; the clear starts only once the pipeline has drained.
  always_comb begin
    state_d      = state;
    ready        = 1'b0;
    start_clear  = 1'b0;
    clear_finish = 1'b0;
    case (state)
      DRAW: begin
        ready = rst_in && !clear_pending;
        if (clear_pending && !s1_valid && !s2_valid) begin
          state_d     = CLEAR;
          start_clear = 1'b1;
        end
      end
      CLEAR: begin
        if (clear_cnt == CLEAR_END) begin
          state_d      = DRAW;
          clear_finish = 1'b1;
        end
      end
      default: state_d = DRAW;
    endcase
  end

  // State register.
  always_ff @(posedge clk_in) begin
    if (!rst_in) state <= DRAW;
    else         state <= state_d;
  end

  // Clear request latch and sweep address counter; requests during a pending/active clear are dropped.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      clear_pending <= 1'b0;
      clear_color   <= '0;
      clear_cnt     <= '0;
    end else begin
      if (state == DRAW && !clear_pending && bus.clear_in) begin
        clear_pending <= 1'b1;
        clear_color   <= bus.clear_color_in;
      end
      if (clear_finish) clear_pending <= 1'b0;
      if (start_clear)                         clear_cnt <= '0;
      else if (state == CLEAR && !clear_finish) clear_cnt <= clear_cnt + 1'b1;
    end
  end

  // Stage 1: capture the accepted beat and its bounds check.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      s1_valid <= 1'b0;
      s1_pix   <= '0;
      s1_color <= '0;
      s1_last  <= 1'b0;
      s1_inb   <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_pix   <= pix_in;
        s1_color <= bus.color_in;
        s1_last  <= bus.last_in;
        s1_inb   <= (32'(pix_in.x) < 32'(WIDTH)) && (32'(pix_in.y) < 32'(HEIGHT));
      end
    end
  end

  // Stage 2: drive the BRAM port from either the pixel pipeline or the clear sweep.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      s2_valid <= 1'b0;
      fb_we    <= 1'b0;
      fb_addr  <= '0;
      fb_data  <= '0;
      tri_done <= 1'b0;
      clipped  <= '0;
    end else begin
      s2_valid <= s1_valid;
      tri_done <= s1_valid && s1_last;
      if (state == CLEAR) begin
        fb_we   <= !clear_finish;
        fb_addr <= clear_cnt[ADDR_WIDTH-1:0];
        fb_data <= clear_color;
      end else begin
        fb_we   <= s1_valid && s1_inb;
        fb_addr <= lin_addr;
        fb_data <= s1_color;
      end
      if (start_clear)
        clipped <= '0;
      else if (s1_valid && !s1_inb && clipped != 16'hFFFF)
        clipped <= clipped + 16'd1;
    end
  end

  assign bus.ready_out         = ready;
  assign bus.busy_out          = clear_pending || (state == CLEAR) || s1_valid || s2_valid;
  assign bus.fb_we_out         = fb_we;
  assign bus.fb_addr_out       = fb_addr;
  assign bus.fb_data_out       = fb_data;
  assign bus.tri_done_out      = tri_done;
  assign bus.clipped_count_out = clipped;
endmodule

// File: doc/fb_pixel_writer.md
Name: fb_pixel_writer

Overview:
- Consumes the pixel stream produced by triangle_color (valid, packed {x,y} coordinate, last) and writes each in-bounds pixel into a single-port framebuffer BRAM at address y*WIDTH+x.
- Adds a ready/valid handshake, so the rasterizer's multi-cycle valid_out is consumed exactly once per beat.
- Provides a full-screen clear sweep and a per-triangle completion pulse.
- Sits between the rasterizer and the framebuffer BRAM write port.

Parameters:
- WIDTH, 40, framebuffer width in pixels.
- HEIGHT, 10, framebuffer height in pixels.
- COLOR_WIDTH, 8, bits per framebuffer word.
- ADDR_WIDTH, 9, framebuffer address width; must satisfy 2**ADDR_WIDTH >= WIDTH*HEIGHT.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous reset, active-low.
- valid_in  input  1  pixel beat valid (from the rasterizer's valid_out).
- pixel_in  input  20  {x[19:10], y[9:0]}, unsigned.
- color_in  input  COLOR_WIDTH  colour for this beat.
- last_in  input  1  final pixel of the current triangle.
- ready_out  output  1  beat accepted on any edge where valid_in && ready_out.
- clear_in  input  1  request a full-framebuffer clear.
- clear_color_in  input  COLOR_WIDTH  clear colour, latched when the clear is requested.
- busy_out  output  1  pipeline non-empty, clear pending, or clear in progress.
- fb_we_out  output  1  BRAM write enable.
- fb_addr_out  output  ADDR_WIDTH  BRAM address.
- fb_data_out  output  COLOR_WIDTH  BRAM write data.
- tri_done_out  output  1  one-cycle pulse when the last_in beat leaves the pipeline.
- clipped_count_out  output  16  count of accepted beats discarded as out of bounds.

Behaviour:
- Reset (rst_in low at an edge): state=DRAW; pipeline empty; clear_pending=0; fb_we_out=0, fb_addr_out=0, fb_data_out=0, tri_done_out=0, clipped_count_out=0, busy_out=0. ready_out is 0 while rst_in is low.
- States:
  - DRAW: ready_out = !clear_pending.
  - CLEAR: ready_out=0.
- Stage 1, at the accept edge, registers:
  - x, y, color, last;
  - inb = (x < WIDTH) && (y < HEIGHT).
- Stage 2, on the next edge, registers:
  - fb_addr_out = y*WIDTH + x, truncated to ADDR_WIDTH;
  - fb_data_out = color;
  - fb_we_out = s1_valid && inb;
  - tri_done_out = s1_valid && last.
- Latency: a beat accepted at edge N drives fb_we_out during the cycle after edge N+1. Throughput is one beat per cycle.
- Out-of-bounds beat:
  - no write (fb_we_out=0);
  - clipped_count_out increments at stage 2 and saturates at 16'hFFFF;
  - tri_done_out still pulses if the beat is last.
- Clear request:
  - clear_in high in DRAW sets clear_pending and latches clear_color_in. ready_out drops from the next cycle.
  - A beat accepted in the same cycle as clear_in is still accepted and written.
  - Once clear_pending=1 and the pipeline is empty: enter CLEAR, counter=0, clipped_count_out=0.
- CLEAR state:
  - each cycle drives fb_we_out=1, fb_addr_out=counter, fb_data_out=latched colour;
  - counter increments each cycle;
  - after address WIDTH*HEIGHT-1 is written, return to DRAW and clear clear_pending.
  - Exactly WIDTH*HEIGHT writes, ascending, no gaps.
- clear_in while clear_pending or in CLEAR: ignored, including a new colour.
- valid_in held during CLEAR: not accepted. The beat is taken on the first DRAW cycle with ready_out=1; no beat is lost or duplicated.
- busy_out = clear_pending || state==CLEAR || s1_valid || s2_valid.
- Reset asserted mid-CLEAR or mid-pipeline: abort immediately to reset values; partial writes are not undone.
- tri_done_out and fb_we_out are never high for more than one cycle per beat.
- Pixel outputs are never high during a CLEAR cycle.

Test Plan:
- WIDTH=40, HEIGHT=10. Accept (x=5, y=3, color=0xAB) at edge N -> fb_we_out=1, fb_addr_out=125, fb_data_out=0xAB for exactly one cycle after edge N+1; busy_out falls afterwards.
- Stream (0,0), (39,9) with last, back-to-back -> consecutive writes to addr 0 and 399; tri_done_out pulses in the same cycle as the addr-399 write.
- Beats (40,0), then (0,10) with last -> no fb_we_out; clipped_count_out=2; tri_done_out pulses once.
- clear_in with clear_color_in=0x11 -> 400 consecutive writes, addr 0..399, data 0x11; ready_out=0 throughout; clipped_count_out reset to 0; back to DRAW with ready_out=1.
- valid_in held with (1,1) during a clear -> accepted exactly once after the clear completes; single write to addr 41.
- rst_in low for 1 cycle at clear address 200 -> all outputs 0 next cycle; after release ready_out=1, no further clear writes.
